// File: rtl/aes_pkg.sv
// Shared AES types and constants for the inverse-cipher datapath blocks.
package aes_pkg;

    // One 128-bit AES state or round key.
    typedef logic [127:0] block_t;

    // AddRoundKey stage control states.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // key store incomplete, no beats accepted
        READY = 2'd1,  // all keys present, waiting for the first beat of a block
        BUSY  = 2'd2   // inside a block, walking rounds downward
    } ark_state_t;

    // Round count for AES-128.
    localparam int AES_NR_128 = 10;

endpackage

// File: rtl/aes_round_key_store.sv
// Round key register file: NR+1 slots of 128 bits with per-slot valid bits.
// One write port, one combinational read port, and an all-valid summary.
module aes_round_key_store
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR_128,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [RIDX_W-1:0] wr_idx_i,
    input  block_t            wr_data_i,
    input  logic [RIDX_W-1:0] rd_idx_i,
    output block_t            rd_data_o,
    output logic              all_valid_o
);

    // Key contents carry no reset; the valid bits alone say whether a slot is usable.
    block_t      keys_q [NR+1];
    logic [NR:0] valid_q;
    logic [NR:0] valid_d;

    // Next valid bits: clear wipes everything, a write marks its slot.
    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    // Valid bit register, lost on reset so the store must be reloaded.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Key data register; a clear in the same cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clear_i) begin
            keys_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Reads see the stored value, so a same-cycle write is not forwarded.
    assign rd_data_o = keys_q[rd_idx_i];

    // Reflects the contents after the coming edge, letting the controller
    // leave EMPTY on the same edge the final key lands.
    assign all_valid_o = &valid_d;

endmodule

// File: rtl/aes_inv_add_round_key.sv
// Inverse-cipher AddRoundKey stage. XORs each incoming state with the round
// key for the current round (NR down to 0) and tags the registered result
// with its round, an InvMixColumns enable and a last-beat marker.
module aes_inv_add_round_key
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR_128,
    parameter int RIDX_W = 4    // 2**RIDX_W must exceed NR
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              key_clear,
    input  logic              key_wr_en,
    input  logic [RIDX_W-1:0] key_wr_idx,
    input  logic [127:0]      key_wr_data,
    output logic              key_wr_ready,
    input  logic              in_valid,
    input  logic              in_first,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out,
    output logic [RIDX_W-1:0] round_out,
    output logic              mix_en,
    output logic              last_out,
    output logic              err
);

    localparam logic [RIDX_W-1:0] NR_IDX  = RIDX_W'(NR);
    localparam logic [RIDX_W-1:0] ONE_IDX = RIDX_W'(1);

    // InvMixColumns is bypassed on the outermost rounds (NR and 0).
    function automatic logic is_mix_round(input logic [RIDX_W-1:0] r);
        return (r != '0) && (r != NR_IDX);
    endfunction

    ark_state_t        state_q, state_d;
    logic [RIDX_W-1:0] cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    block_t            data_q, data_d;
    logic [RIDX_W-1:0] round_q, round_d;
    logic              mix_q, mix_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              accept;
    logic              key_wr_ok;
    logic              all_valid;
    logic [RIDX_W-1:0] rd_idx;
    block_t            rd_key;

    assign key_wr_ready = (state_q != BUSY);
    assign in_ready     = (state_q != EMPTY) && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;

    // Out-of-range indices and writes during a block never reach the store.
    assign key_wr_ok = key_wr_en && key_wr_ready && (key_wr_idx <= NR_IDX) && !key_clear;

    // A first beat always uses the outermost key, regardless of the counter.
    assign rd_idx = in_first ? NR_IDX : cnt_q;

    aes_round_key_store #(
        .NR     (NR),
        .RIDX_W (RIDX_W)
    ) u_key_store (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear_i     (key_clear),
        .wr_en_i     (key_wr_ok),
        .wr_idx_i    (key_wr_idx),
        .wr_data_i   (key_wr_data),
        .rd_idx_i    (rd_idx),
        .rd_data_o   (rd_key),
        .all_valid_o (all_valid)
    );

    // Next-state logic: FSM, round counter, error flag and output holding register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        round_d     = round_q;
        mix_d       = mix_q;
        last_d      = last_q;
        err_d       = err_q;

        // The held beat retires when downstream takes it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (key_clear) begin
            // Overrides any beat or key write presented in the same cycle.
            state_d = EMPTY;
            cnt_d   = NR_IDX;
            err_d   = 1'b0;
        end else begin
            if (key_wr_en && ((state_q == BUSY) || (key_wr_idx > NR_IDX))) begin
                err_d = 1'b1;
            end

            // Every beat that produces output is loaded here; stalls keep it stable.
            if (accept && (in_first || (state_q == BUSY))) begin
                out_valid_d = 1'b1;
                data_d      = data_in ^ rd_key;
                round_d     = rd_idx;
                mix_d       = is_mix_round(rd_idx);
                last_d      = (rd_idx == '0);
            end

            case (state_q)
                EMPTY: begin
                    if (all_valid) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (accept) begin
                        if (in_first) begin
                            state_d = BUSY;
                            cnt_d   = NR_IDX - ONE_IDX;
                        end else begin
                            // Mid-block beat with no block open: drop it and flag.
                            err_d = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (in_first) begin
                            // Abandon the current block and restart from round NR.
                            err_d = 1'b1;
                            cnt_d = NR_IDX - ONE_IDX;
                        end else if (cnt_q == '0) begin
                            state_d = READY;
                            cnt_d   = NR_IDX;
                        end else begin
                            cnt_d = cnt_q - ONE_IDX;
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                    cnt_d   = NR_IDX;
                end
            endcase
        end
    end

    // Control and output registers; reset clears everything including in-flight output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= EMPTY;
            cnt_q       <= NR_IDX;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            round_q     <= '0;
            mix_q       <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            round_q     <= round_d;
            mix_q       <= mix_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign round_out = round_q;
    assign mix_en    = mix_q;
    assign last_out  = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_aes_inv_add_round_key.sv
// Directed bench for aes_inv_add_round_key using the FIPS-197 C.1 key schedule.
module tb_aes_inv_add_round_key;

    logic         clk;
    logic         n_rst;
    logic         key_clear;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;
    logic         key_wr_ready;
    logic         in_valid;
    logic         in_first;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [3:0]   round_out;
    logic         mix_en;
    logic         last_out;
    logic         err;

    int checks;
    int failures;

    logic [127:0] K [0:10];
    logic [127:0] newk;
    logic [127:0] x_data;

    aes_inv_add_round_key #(.NR(10), .RIDX_W(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .key_clear    (key_clear),
        .key_wr_en    (key_wr_en),
        .key_wr_idx   (key_wr_idx),
        .key_wr_data  (key_wr_data),
        .key_wr_ready (key_wr_ready),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .round_out    (round_out),
        .mix_en       (mix_en),
        .last_out     (last_out),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input int idx, input logic [127:0] val);
        key_wr_en   = 1'b1;
        key_wr_idx  = 4'(idx);
        key_wr_data = val;
        tick();
        key_wr_en   = 1'b0;
    endtask

    function automatic logic [127:0] pat(input int r);
        return {4{32'hA5C30000 | 32'(r * 17)}};
    endfunction

    // Check one output beat against the bench's key table.
    task automatic chk_beat(input string tag, input int r, input logic [127:0] din);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        chk({tag, "_data"},  data_out, din ^ K[r]);
        chk({tag, "_round"}, 128'(round_out), 128'(r));
        chk({tag, "_mix"},   128'(mix_en), 128'((r > 0) && (r < 10)));
        chk({tag, "_last"},  128'(last_out), 128'(r == 0));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        K[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        K[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        K[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        K[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        K[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        K[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        K[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        K[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        K[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        K[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        K[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        newk  = 128'h0123456789abcdeffedcba9876543210;

        n_rst = 1'b0; key_clear = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0;
        key_wr_data = '0; in_valid = 1'b0; in_first = 1'b0; data_in = '0; out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_round", 128'(round_out), 128'h0);
        chk("rst_mix", 128'(mix_en), 128'h0);
        chk("rst_last", 128'(last_out), 128'h0);
        chk("rst_err", 128'(err), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'h0);
        chk("rst_wr_ready", 128'(key_wr_ready), 128'h1);
        n_rst = 1'b1;
        tick();

        // Partial key load keeps the stage closed
        for (int i = 0; i < 10; i++) write_key(i, K[i]);
        tick();
        chk("partial_in_ready", 128'(in_ready), 128'h0);
        chk("partial_wr_ready", 128'(key_wr_ready), 128'h1);
        write_key(10, K[10]);
        chk("full_in_ready", 128'(in_ready), 128'h1);

        // FIPS-197 C.1 first inverse round
        in_valid = 1'b1; in_first = 1'b1; data_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tick();
        chk("c1_data", data_out, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        chk("c1_round", 128'(round_out), 128'd10);
        chk("c1_mix", 128'(mix_en), 128'h0);
        chk("c1_valid", 128'(out_valid), 128'h1);
        chk("c1_busy", 128'(key_wr_ready), 128'h0);

        // Remainder of the block, back to back
        in_first = 1'b0;
        for (int r = 9; r >= 0; r--) begin
            data_in = pat(r);
            tick();
            chk_beat("blk", r, pat(r));
        end
        in_valid = 1'b0;
        chk("blk_ready_state", 128'(key_wr_ready), 128'h1);
        chk("blk_err", 128'(err), 128'h0);
        tick();
        chk("blk_drained", 128'(out_valid), 128'h0);

        // Backpressure: output held for 3 cycles, waiting beat not lost
        x_data = 128'hdeadbeef00112233445566778899aabb;
        in_valid = 1'b1; in_first = 1'b1; data_in = x_data;
        tick();
        chk_beat("stall_first", 10, x_data);
        out_ready = 1'b0; in_first = 1'b0; data_in = pat(9);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_data", data_out, x_data ^ K[10]);
            chk("stall_round", 128'(round_out), 128'd10);
            chk("stall_in_ready", 128'(in_ready), 128'h0);
        end
        out_ready = 1'b1;
        for (int r = 9; r >= 6; r--) begin
            data_in = pat(r);
            tick();
            chk_beat("flow", r, pat(r));
        end

        // Abort at round 6 with a new first beat
        in_first = 1'b1; data_in = 128'hcafef00d;
        tick();
        chk_beat("abort", 10, 128'hcafef00d);
        chk("abort_err", 128'(err), 128'h1);
        in_valid = 1'b0; in_first = 1'b0;
        key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = '1;
        #1;
        chk("busy_wr_ready", 128'(key_wr_ready), 128'h0);
        tick();
        key_wr_en = 1'b0;
        chk("busy_wr_err", 128'(err), 128'h1);
        in_valid = 1'b1;
        for (int r = 9; r >= 3; r--) begin
            data_in = pat(r);
            tick();
            chk_beat("resume", r, pat(r));
        end
        in_valid = 1'b0;

        // Reset in the middle of a block
        n_rst = 1'b0;
        #1;
        chk("mrst_valid", 128'(out_valid), 128'h0);
        chk("mrst_data", data_out, 128'h0);
        chk("mrst_round", 128'(round_out), 128'h0);
        chk("mrst_mix", 128'(mix_en), 128'h0);
        chk("mrst_last", 128'(last_out), 128'h0);
        chk("mrst_err", 128'(err), 128'h0);
        chk("mrst_in_ready", 128'(in_ready), 128'h0);
        chk("mrst_wr_ready", 128'(key_wr_ready), 128'h1);
        tick();
        n_rst = 1'b1;
        tick();
        tick();
        chk("mrst_keys_lost", 128'(in_ready), 128'h0);
        for (int i = 0; i <= 10; i++) write_key(i, K[i]);
        chk("reload_in_ready", 128'(in_ready), 128'h1);

        // Non-first beat while READY is consumed with an error
        in_valid = 1'b1; in_first = 1'b0; data_in = pat(4);
        tick();
        in_valid = 1'b0;
        chk("orphan_no_out", 128'(out_valid), 128'h0);
        chk("orphan_err", 128'(err), 128'h1);
        chk("orphan_ready", 128'(key_wr_ready), 128'h1);

        // Same-cycle key rewrite and first beat: beat sees the old key
        key_wr_en = 1'b1; key_wr_idx = 4'd10; key_wr_data = newk;
        in_valid = 1'b1; in_first = 1'b1; data_in = 128'h1111;
        tick();
        key_wr_en = 1'b0;
        chk("samecyc_old_key", data_out, 128'h1111 ^ K[10]);
        data_in = 128'h2222;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        chk("samecyc_new_key", data_out, 128'h2222 ^ newk);
        chk("samecyc_round", 128'(round_out), 128'd10);

        // key_clear empties the store and clears the error
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clear_err", 128'(err), 128'h0);
        chk("clear_in_ready", 128'(in_ready), 128'h0);
        chk("clear_wr_ready", 128'(key_wr_ready), 128'h1);

        // Out-of-range key index
        write_key(11, newk);
        chk("badidx_err", 128'(err), 128'h1);
        tick();
        chk("badidx_still_empty", 128'(in_ready), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
